seven_seg_capture: RTL and testbench
====================================

// Module: seven_seg_capture
// PURPOSE
//  Receive side of the multiplexed 7-segment display bus: snoops the active-low anode
//  and segment lines driven by the display scan logic and rebuilds the 8 hex digits.
//  Segment patterns are decoded back to 4-bit values after a stability filter.
//  Used as an on-chip readback/self-check of the display path and as a bench monitor.
// PARAMETERS
//  SETTLE_CYCLES  4  consecutive cycles an/seg must be unchanged before capture (1..255)
// PORTS
//  clk          in   1   system clock; the single clock of the block
//  reset        in   1   synchronous, active-high reset
//  an           in   8   anodes, active low; an[k] = AN<k>, selects digit k
//  seg          in   7   {CA,CB,CC,CD,CE,CF,CG}, active low
//  clr_err      in   1   clears err_pattern and err_anode (reset has priority)
//  digits       out  32  digit k at digits[4k+3:4k]
//  digit_valid  out  8   bit k = digit k holds a successfully decoded value
//  frame_done   out  1   one-cycle pulse: every digit captured since last pulse
//  err_pattern  out  1   sticky: undecodable segment pattern captured
//  err_anode    out  1   sticky: more than one anode low while stable
// BEHAVIOUR
//  - Reset (sync, high): digits=0, digit_valid=0, frame_done=0, errors=0, seen mask=0,
//    stable counter=0, state=WAIT. Reset mid-settle discards the pending capture.
//  - an/seg registered once on entry (r_an, r_seg); all logic uses registered copies.
//  - Stability: counter cleared whenever {r_an,r_seg} differs from previous cycle,
//    else increments, saturating at SETTLE_CYCLES.
//  - FSM: WAIT -> SETTLE when r_an has exactly one bit low; r_an all ones stays WAIT.
//    SETTLE -> CAPTURE when counter reaches SETTLE_CYCLES; any change -> back to SETTLE
//    (counter restarts). CAPTURE (1 cycle) -> HOLD. HOLD -> SETTLE on any an/seg change.
//    Same digit is captured once per stable window; no re-capture while held.
//  - Latency: pair at input before edge e0 and held -> digits/digit_valid update at
//    edge e0+SETTLE_CYCLES+1.
//  - Decode (CAPTURE): 0000001=0 1001111=1 0010010=2 0000110=3 1001100=4 0100100=5
//    0100000=6 0001111=7 0000000=8 0000100=9 0001000=A 1100000=b 0110001=C
//    1000010=d 0110000=E 0111000=F. Hit: digits[k] written, digit_valid[k]=1.
//    Miss: digits[k] held, digit_valid[k]=0, err_pattern=1.
//  - Any capture (hit or miss) sets seen[k]. When seen becomes 8'hFF, frame_done
//    pulses in the same cycle the outputs update; seen cleared to 0 that cycle.
//  - Two or more r_an bits low for SETTLE_CYCLES stable cycles: err_anode=1, no
//    capture, seen unchanged; FSM to HOLD until change.
//  - clr_err and a new error in same cycle: error wins (stays 1).
// CONFIGURATION
//  SEVSEG_CAPTURE_BLANK_EN defined: seg=7'b1111111 is a legal blank: no err_pattern,
//    digits[k] held, digit_valid[k]=0, seen[k] set.
//  Not defined: all-off pattern is a decode miss (err_pattern=1, digit_valid[k]=0).
// TESTING (SETTLE_CYCLES=4 unless noted)
//  1 reset high 2 cycles -> digits=0, digit_valid=0, frame_done=0, both errors 0.
//  2 an=8'hFE, seg=7'b0010010 held -> digits[3:0]=2, digit_valid[0]=1 exactly at
//    edge e0+5; glitch seg at edge e0+3 -> capture moves to 5 edges after glitch end.
//  3 scan digits 0..7 with values 1..8, 8 cycles each -> digits=32'h87654321,
//    digit_valid=8'hFF, frame_done one pulse at digit 7 capture; repeat -> pulse again.
//  4 an=8'hFC stable -> err_anode=1, no digit written; clr_err -> 0; an=8'hFF idles.
//  5 an=8'hF7, seg=7'b1111111 -> without macro err_pattern=1, digit_valid[3]=0;
//    with SEVSEG_CAPTURE_BLANK_EN err_pattern=0, digits[15:12] unchanged.
//  6 reset asserted at settle count 3 -> no capture, all outputs 0 next cycle.

Source files
------------

// File: rtl/seven_seg_capture.sv
// seven_seg_capture: rebuilds 8 hex digits by snooping a multiplexed active-low 7-segment bus.
// Optional SEVSEG_CAPTURE_BLANK_EN treats the all-off segment pattern as a legal blank digit.
module seven_seg_capture #(
    parameter int SETTLE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  an,
    input  logic [6:0]  seg,
    input  logic        clr_err,
    output logic [31:0] digits,
    output logic [7:0]  digit_valid,
    output logic        frame_done,
    output logic        err_pattern,
    output logic        err_anode
);
    typedef enum logic [1:0] {S_WAIT, S_SETTLE, S_CAPTURE, S_HOLD} state_t;

    localparam logic [7:0] SETTLE = 8'(SETTLE_CYCLES);

    function automatic logic [4:0] decode(input logic [6:0] s);
        case (s)
            7'b0000001: decode = 5'h10;
            7'b1001111: decode = 5'h11;
            7'b0010010: decode = 5'h12;
            7'b0000110: decode = 5'h13;
            7'b1001100: decode = 5'h14;
            7'b0100100: decode = 5'h15;
            7'b0100000: decode = 5'h16;
            7'b0001111: decode = 5'h17;
            7'b0000000: decode = 5'h18;
            7'b0000100: decode = 5'h19;
            7'b0001000: decode = 5'h1A;
            7'b1100000: decode = 5'h1B;
            7'b0110001: decode = 5'h1C;
            7'b1000010: decode = 5'h1D;
            7'b0110000: decode = 5'h1E;
            7'b0111000: decode = 5'h1F;
            default:    decode = 5'h00;
        endcase
    endfunction

    state_t      state_q, state_d;
    logic [7:0]  r_an_q;
    logic [6:0]  r_seg_q;
    logic [14:0] prev_q;
    logic [7:0]  cnt_q, cnt_d;
    logic [7:0]  seen_q, seen_d;
    logic [31:0] digits_q, digits_d;
    logic [7:0]  valid_q, valid_d;
    logic        frame_done_q, frame_done_d;
    logic        err_pattern_q, err_pattern_d;
    logic        err_anode_q, err_anode_d;
    logic        changed, one_low, multi_low, fire, blank;
    logic [7:0]  lows;
    logic [4:0]  dec;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_WAIT;
            r_an_q        <= 8'hFF;
            r_seg_q       <= 7'h7F;
            prev_q        <= {8'hFF, 7'h7F};
            cnt_q         <= '0;
            seen_q        <= '0;
            digits_q      <= '0;
            valid_q       <= '0;
            frame_done_q  <= 1'b0;
            err_pattern_q <= 1'b0;
            err_anode_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            r_an_q        <= an;
            r_seg_q       <= seg;
            prev_q        <= {r_an_q, r_seg_q};
            cnt_q         <= cnt_d;
            seen_q        <= seen_d;
            digits_q      <= digits_d;
            valid_q       <= valid_d;
            frame_done_q  <= frame_done_d;
            err_pattern_q <= err_pattern_d;
            err_anode_q   <= err_anode_d;
        end
    end

    always_comb begin
        changed   = {r_an_q, r_seg_q} != prev_q;
        cnt_d     = changed ? 8'd0 : (cnt_q == SETTLE ? cnt_q : cnt_q + 8'd1);
        lows      = ~r_an_q;
        one_low   = $onehot(lows);
        multi_low = (lows != 8'd0) && !one_low;
        fire      = (state_q == S_SETTLE) && !changed && (cnt_d == SETTLE);
        dec       = decode(r_seg_q);
`ifdef SEVSEG_CAPTURE_BLANK_EN
        blank     = r_seg_q == 7'h7F;
`else
        blank     = 1'b0;
`endif
        state_d = state_q;
        case (state_q)
            S_WAIT:    state_d = (r_an_q != 8'hFF) ? S_SETTLE : S_WAIT;
            S_SETTLE:  state_d = (r_an_q == 8'hFF) ? S_WAIT : fire ? (one_low ? S_CAPTURE : S_HOLD) : S_SETTLE;
            S_CAPTURE: state_d = changed ? S_SETTLE : S_HOLD;
            default:   state_d = changed ? ((r_an_q == 8'hFF) ? S_WAIT : S_SETTLE) : S_HOLD;
        endcase
        digits_d      = digits_q;
        valid_d       = valid_q;
        seen_d        = seen_q;
        frame_done_d  = 1'b0;
        err_pattern_d = clr_err ? 1'b0 : err_pattern_q;
        err_anode_d   = clr_err ? 1'b0 : err_anode_q;
        if (fire && multi_low)
            err_anode_d = 1'b1;
        if (fire && one_low) begin
            for (int i = 0; i < 8; i++)
                if (lows[i]) begin
                    if (dec[4])
                        digits_d[4*i +: 4] = dec[3:0];
                    valid_d[i] = dec[4];
                end
            if (!dec[4] && !blank)
                err_pattern_d = 1'b1;
            seen_d = seen_q | lows;
            // A completed frame restarts the seen mask in the same cycle it pulses.
            if (seen_d == 8'hFF) begin
                frame_done_d = 1'b1;
                seen_d       = 8'h00;
            end
        end
    end

    assign digits      = digits_q;
    assign digit_valid = valid_q;
    assign frame_done  = frame_done_q;
    assign err_pattern = err_pattern_q;
    assign err_anode   = err_anode_q;
endmodule

// File: tb/tb_seven_seg_capture.sv
// tb_seven_seg_capture: directed stimulus with a window-based reference model checked every cycle.
module tb_seven_seg_capture;
    localparam int SETTLE_CYCLES = 4;
`ifdef SEVSEG_CAPTURE_BLANK_EN
    localparam bit BLANK_EN = 1'b1;
`else
    localparam bit BLANK_EN = 1'b0;
`endif

    logic        clk, reset, clr_err;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic [31:0] digits;
    logic [7:0]  digit_valid;
    logic        frame_done, err_pattern, err_anode;

    int checks = 0;
    int errors = 0;
    int fd_cnt = 0;

    logic [6:0] pat [0:15] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                               7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                               7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                               7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

    seven_seg_capture #(.SETTLE_CYCLES(SETTLE_CYCLES)) dut (
        .clk(clk), .reset(reset), .an(an), .seg(seg), .clr_err(clr_err),
        .digits(digits), .digit_valid(digit_valid), .frame_done(frame_done),
        .err_pattern(err_pattern), .err_anode(err_anode)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Model: a pair seen unchanged for SETTLE_CYCLES+1 consecutive samples is captured once.
    logic [31:0] m_digits;
    logic [7:0]  m_valid, m_seen;
    bit          m_fd, m_ep, m_ea, m_live;
    logic [14:0] m_pair;
    int          m_run;

    always @(posedge clk) begin
        int k, v;
        if (reset) begin
            m_digits = '0; m_valid = '0; m_seen = '0;
            m_fd = 0; m_ep = 0; m_ea = 0; m_live = 1;
            m_pair = {8'hFF, 7'h7F}; m_run = 1;
        end else begin
            m_fd = 0;
            if (clr_err) begin m_ep = 0; m_ea = 0; end
            if (m_run == SETTLE_CYCLES + 1 && m_pair[14:7] != 8'hFF) begin
                if ($countones(~m_pair[14:7]) > 1) m_ea = 1;
                else begin
                    k = 0; v = -1;
                    for (int i = 0; i < 8; i++) if (!m_pair[7+i]) k = i;
                    for (int i = 0; i < 16; i++) if (pat[i] == m_pair[6:0]) v = i;
                    if (v >= 0) begin m_digits[4*k +: 4] = 4'(v); m_valid[k] = 1; end
                    else begin
                        m_valid[k] = 0;
                        if (!(BLANK_EN && m_pair[6:0] == 7'h7F)) m_ep = 1;
                    end
                    m_seen[k] = 1;
                    if (m_seen == 8'hFF) begin m_fd = 1; m_seen = 0; end
                end
            end
            if ({an, seg} == m_pair) begin if (m_run < 100) m_run++; end
            else begin m_pair = {an, seg}; m_run = 1; end
        end
    end

    always @(negedge clk) begin
        if (m_live) begin
            chk("digits", digits, m_digits);
            chk("digit_valid", {24'd0, digit_valid}, {24'd0, m_valid});
            chk("frame_done", {31'd0, frame_done}, {31'd0, m_fd});
            chk("err_pattern", {31'd0, err_pattern}, {31'd0, m_ep});
            chk("err_anode", {31'd0, err_anode}, {31'd0, m_ea});
            if (frame_done) fd_cnt++;
        end
    end

    initial begin
        m_live = 0;
        an = 8'hFF; seg = 7'h7F; clr_err = 0; reset = 1;
        step(2);
        reset = 0;
        chk("rst_digits", digits, 32'h0);
        chk("rst_valid", {24'd0, digit_valid}, 32'h0);
        chk("rst_errs", {30'd0, err_pattern, err_anode}, 32'h0);
        chk("rst_fd", {31'd0, frame_done}, 32'h0);
        // latency: capture exactly SETTLE_CYCLES+1 edges after the pair arrives
        an = 8'hFE; seg = 7'b0010010;
        step(5);
        chk("lat_early_valid", {24'd0, digit_valid}, 32'h0);
        step(1);
        chk("lat_valid", {24'd0, digit_valid}, 32'h1);
        chk("lat_digit", {28'd0, digits[3:0]}, 32'h2);
        // one-cycle glitch restarts the settle window
        an = 8'hFD; seg = pat[3];
        step(3);
        seg = 7'b1111110;
        step(1);
        seg = pat[3];
        step(5);
        chk("glitch_early", {31'd0, digit_valid[1]}, 32'h0);
        step(1);
        chk("glitch_valid", {31'd0, digit_valid[1]}, 32'h1);
        chk("glitch_digit", {28'd0, digits[7:4]}, 32'h3);
        // full scans
        reset = 1; step(1); reset = 0; fd_cnt = 0;
        for (int k = 0; k < 8; k++) begin an = ~(8'h01 << k); seg = pat[k+1]; step(8); end
        chk("scan1_digits", digits, 32'h87654321);
        chk("scan1_valid", {24'd0, digit_valid}, 32'hFF);
        chk("scan1_frames", fd_cnt, 1);
        for (int k = 0; k < 8; k++) begin an = ~(8'h01 << k); seg = pat[(k+9)%16]; step(8); end
        chk("scan2_digits", digits, 32'h0FEDCBA9);
        chk("scan2_frames", fd_cnt, 2);
        // multiple anodes
        an = 8'hFC; seg = pat[5];
        step(8);
        chk("anode_err", {31'd0, err_anode}, 32'h1);
        chk("anode_digits", digits, 32'h0FEDCBA9);
        clr_err = 1; step(1); clr_err = 0;
        chk("anode_clr", {31'd0, err_anode}, 32'h0);
        an = 8'hFF;
        step(8);
        chk("idle_err", {31'd0, err_anode}, 32'h0);
        // blank pattern
        an = 8'hF7; seg = 7'h7F;
        step(8);
        chk("blank_digit", {28'd0, digits[15:12]}, 32'hC);
        chk("blank_valid", {31'd0, digit_valid[3]}, 32'h0);
        chk("blank_err", {31'd0, err_pattern}, BLANK_EN ? 32'h0 : 32'h1);
        clr_err = 1; step(1); clr_err = 0;
        an = 8'hFB; seg = 7'b1010101;
        step(8);
        chk("bad_err", {31'd0, err_pattern}, 32'h1);
        chk("bad_valid", {31'd0, digit_valid[2]}, 32'h0);
        chk("bad_digit", {28'd0, digits[11:8]}, 32'hB);
        // reset mid-settle
        an = 8'hFF; step(2);
        an = 8'hFE; seg = pat[8];
        step(4);
        reset = 1; step(1); reset = 0;
        chk("midrst_digits", digits, 32'h0);
        chk("midrst_valid", {24'd0, digit_valid}, 32'h0);
        chk("midrst_errs", {30'd0, err_pattern, err_anode}, 32'h0);
        step(8);
        chk("post_digit", {28'd0, digits[3:0]}, 32'h8);
        chk("post_valid", {24'd0, digit_valid}, 32'h1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
